// File: rtl/sha256_round_ctrl_if.sv
// Handshake and strobe bundle between the block requester, the SHA-256 round
// controller and the compression datapath it sequences.
interface sha256_round_ctrl_if;
    logic       start;
    logic       first;
    logic       abort;
    logic       ready;
    logic       busy;
    logic       ld_h_iv;
    logic       ld_msg;
    logic       ld_work;
    logic       rnd_en;
    logic       w_sched;
    logic [5:0] round;
    logic       upd_h;
    logic       done;

    modport master (
        output start, first, abort,
        input  ready, busy, ld_h_iv, ld_msg, ld_work, rnd_en, w_sched, round, upd_h, done
    );

    modport slave (
        input  start, first, abort,
        output ready, busy, ld_h_iv, ld_msg, ld_work, rnd_en, w_sched, round, upd_h, done
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: steps one block through IV init, load,
// ROUNDS compression rounds and the H update, with abort and restart.
module sha256_round_ctrl #(
    parameter int unsigned ROUNDS    = 64,
    parameter int unsigned MSG_WORDS = 16
) (
    input logic                i_clk,
    input logic                i_rst,
    sha256_round_ctrl_if.slave io_ctl
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [6:0] SCHED_FROM = 7'(MSG_WORDS);

    state_t     r_state;
    logic [5:0] r_round;
    logic       r_ready;
    logic       r_busy;
    logic       r_ld_h_iv;
    logic       r_ld_msg;
    logic       r_rnd_en;
    logic       r_w_sched;
    logic       r_upd_h;
    logic       r_done;

    state_t     w_nxt_state;
    logic [5:0] w_nxt_round;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_round = r_round;
        case (r_state)
            ST_IDLE: begin
                if (!io_ctl.abort && io_ctl.start)
                    w_nxt_state = io_ctl.first ? ST_INIT : ST_LOAD;
            end
            ST_INIT:   w_nxt_state = ST_LOAD;
            ST_LOAD: begin
                w_nxt_state = ST_ROUND;
                w_nxt_round = '0;
            end
            ST_ROUND: begin
                if (r_round == LAST_ROUND) begin
                    w_nxt_state = ST_UPDATE;
                    w_nxt_round = '0;
                end else begin
                    w_nxt_round = r_round + 6'd1;
                end
            end
            ST_UPDATE: w_nxt_state = ST_DONE;
            ST_DONE:   w_nxt_state = ST_IDLE;
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_round = '0;
            end
        endcase
        // Abort only applies while a block is in flight; DONE always completes.
        if (io_ctl.abort && (r_state inside {ST_INIT, ST_LOAD, ST_ROUND, ST_UPDATE})) begin
            w_nxt_state = ST_IDLE;
            w_nxt_round = '0;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_round   <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_ld_h_iv <= 1'b0;
            r_ld_msg  <= 1'b0;
            r_rnd_en  <= 1'b0;
            r_w_sched <= 1'b0;
            r_upd_h   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_round   <= w_nxt_round;
            r_ready   <= (w_nxt_state == ST_IDLE);
            r_busy    <= (w_nxt_state inside {ST_INIT, ST_LOAD, ST_ROUND, ST_UPDATE});
            r_ld_h_iv <= (w_nxt_state == ST_INIT);
            r_ld_msg  <= (w_nxt_state == ST_LOAD);
            r_rnd_en  <= (w_nxt_state == ST_ROUND);
            r_w_sched <= (w_nxt_state == ST_ROUND) && ({1'b0, w_nxt_round} >= SCHED_FROM);
            r_upd_h   <= (w_nxt_state == ST_UPDATE);
            r_done    <= (w_nxt_state == ST_DONE);
        end
    end

    assign io_ctl.ready   = r_ready;
    assign io_ctl.busy    = r_busy;
    assign io_ctl.ld_h_iv = r_ld_h_iv;
    assign io_ctl.ld_msg  = r_ld_msg;
    assign io_ctl.ld_work = r_ld_msg;
    assign io_ctl.rnd_en  = r_rnd_en;
    assign io_ctl.w_sched = r_w_sched;
    assign io_ctl.round   = r_round;
    assign io_ctl.upd_h   = r_upd_h;
    assign io_ctl.done    = r_done;
endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequencer for the SHA-256 compression datapath: the working registers a..h, the message schedule W, the round constant lookup and the intermediate hash H.
- Accepts one 512-bit block per start handshake and drives load, enable and select strobes through init, load, round and update phases.
- Sits between the message padder/block buffer and the compression datapath. It contains no hashing arithmetic itself.

Parameters:
- ROUNDS, 64, number of compression rounds per block (legal range 17..64; 64 for SHA-256).
- MSG_WORDS, 16, number of rounds that take W directly from the loaded block before the schedule recurrence takes over.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to process the block currently presented to the datapath.
- first  input  1  sampled with start; 1 = first block of a message, so H is initialised to the IV.
- abort  input  1  synchronous abandon of the current block.
- ready  output  1  controller is in IDLE and can accept start.
- busy  output  1  controller is in INIT, LOAD, ROUND or UPDATE.
- ld_h_iv  output  1  load the H registers with the SHA-256 IV.
- ld_msg  output  1  capture the 16 block words into the W schedule.
- ld_work  output  1  copy H into a..h.
- rnd_en  output  1  advance a..h by one round and shift the schedule.
- w_sched  output  1  0 = W_t taken from the block word, 1 = W_t taken from the sigma recurrence.
- round  output  6  current round index t, used to address the K constant.
- upd_h  output  1  H <= H + a..h.
- done  output  1  one-cycle pulse: H now holds the result for this block.

Behaviour:
- FSM states: IDLE, INIT, LOAD, ROUND, UPDATE, DONE. Encoding is free. All outputs are decoded from registered state and counter (Moore); no combinational path from inputs to outputs.
- Reset (rst=1 at a clk edge): state goes to IDLE and round goes to 0. While in reset, every output is 0 except ready=1. Reset takes priority over every other input, including mid-block.
- IDLE: ready=1, all strobes 0.
  - start=1 and first=1: go to INIT.
  - start=1 and first=0: go to LOAD.
  - first is ignored unless start=1.
- INIT (exactly 1 cycle): ld_h_iv=1, then go to LOAD.
- LOAD (exactly 1 cycle): ld_msg=1 and ld_work=1, round <= 0, then go to ROUND.
- ROUND (exactly ROUNDS cycles):
  - rnd_en=1 on every cycle.
  - round counts 0..ROUNDS-1, one increment per cycle.
  - w_sched = (round >= MSG_WORDS).
  - On the cycle with round == ROUNDS-1, go to UPDATE and return round to 0.
- UPDATE (1 cycle): upd_h=1, then go to DONE.
- DONE (1 cycle): done=1, busy=0, ready=0, then go to IDLE.
- Latency: start sampled at edge N gives done=1 in cycle N+ROUNDS+3 (first=0) or N+ROUNDS+4 (first=1). The next start is accepted no earlier than the cycle after done.
- start while busy or in DONE: ignored. It is not queued; the requester must hold or reissue it once ready=1.
- abort=1 at an edge in INIT, LOAD, ROUND or UPDATE: next state is IDLE and round=0. done is not pulsed and upd_h is not issued. H contents are undefined afterwards, so the next block must use first=1.
- abort in IDLE or DONE: no effect. DONE still completes and its pulse is emitted.
- abort and start together in IDLE: abort wins, start is ignored.
- Strobe exclusivity: at most one of ld_h_iv, ld_msg/ld_work (which assert together), rnd_en, upd_h is 1 in any cycle.
- w_sched and round are 0 outside ROUND.
- Round counter: 6-bit, never exceeds ROUNDS-1, no wrap-around within a block.

Test Plan:
- Reset mid-block: assert rst at round=30 → next cycle ready=1, round=0, all strobes 0; a subsequent start/first=1 produces done at start+68.
- First block: start=1, first=1 at cycle 0 → ld_h_iv in cycle 1; ld_msg and ld_work in cycle 2; rnd_en in cycles 3..66 with round 0..63; w_sched rises in cycle 19 (round 16); upd_h in cycle 67; done in cycle 68; ready back to 1 in cycle 69.
- Continuation block: start=1, first=0 → no ld_h_iv; ld_msg in cycle 1; done in cycle 67; a back-to-back start on the first ready cycle is accepted.
- Ignored start: pulse start at round=10 and during DONE → no state change; exactly one done pulse; rnd_en count = 64.
- Abort: abort at round=63 → no upd_h and no done; ready=1 on the next cycle. Abort together with start in IDLE → stays in IDLE.
- Parameter sweep: ROUNDS=20, MSG_WORDS=16 → rnd_en asserted for exactly 20 cycles; w_sched high for rounds 16..19; strobe exclusivity assertion holds on every cycle.
